// File: rtl/ee354_snake_pkg.sv
// Shared direction/state encodings and default geometry for the snake engine.
// Direction codes match the controller's Dir_In encoding.
package ee354_snake_pkg;

    typedef enum logic [1:0] {
        DIR_R = 2'b00,
        DIR_L = 2'b01,
        DIR_U = 2'b10,
        DIR_D = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        S_INIT   = 2'b00,
        S_WAIT   = 2'b01,
        S_SCAN   = 2'b10,
        S_COMMIT = 2'b11
    } eng_state_t;

    localparam int GRID_DEF     = 15;
    localparam int INIT_LEN_DEF = 3;
    localparam int CW_DEF       = 4;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_R:   return DIR_L;
            DIR_L:   return DIR_R;
            DIR_U:   return DIR_D;
            default: return DIR_U;
        endcase
    endfunction

endpackage

// File: rtl/ee354_snake_engine_if.sv
// Bundle of controller, food, status and render-port signals for the snake engine.
// master = controller/renderer side, slave = engine side.
interface ee354_snake_engine_if #(parameter int CW = 4);

    logic          q_I;
    logic          q_Run;
    logic          Tick;
    logic [1:0]    Dir_In;
    logic          Dir_Valid;
    logic [CW-1:0] Food_X;
    logic [CW-1:0] Food_Y;
    logic          Collision;
    logic [7:0]    Length;
    logic          Ate;
    logic [CW-1:0] Head_X;
    logic [CW-1:0] Head_Y;
    logic          Busy;
    logic [7:0]    Rd_Idx;
    logic [CW-1:0] Rd_X;
    logic [CW-1:0] Rd_Y;
    logic          Rd_Vld;

    modport master (
        output q_I, q_Run, Tick, Dir_In, Dir_Valid, Food_X, Food_Y, Rd_Idx,
        input  Collision, Length, Ate, Head_X, Head_Y, Busy, Rd_X, Rd_Y, Rd_Vld
    );

    modport slave (
        input  q_I, q_Run, Tick, Dir_In, Dir_Valid, Food_X, Food_Y, Rd_Idx,
        output Collision, Length, Ate, Head_X, Head_Y, Busy, Rd_X, Rd_Y, Rd_Vld
    );

endinterface

// File: rtl/ee354_snake_ring.sv
// 256-entry body ring: one write port, asynchronous scan read, registered render read.
// Preset loads the initial horizontal snake ending at index 0 (head) and wrapping below it.
module ee354_snake_ring #(
    parameter int            CW       = 4,
    parameter int            INIT_LEN = 3,
    parameter logic [CW-1:0] HX0      = 4'd7,
    parameter logic [CW-1:0] HY0      = 4'd7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_preset,
    input  logic            i_we,
    input  logic [7:0]      i_waddr,
    input  logic [2*CW-1:0] i_wdata,
    input  logic [7:0]      i_scan_addr,
    output logic [2*CW-1:0] o_scan_data,
    input  logic [7:0]      i_rd_addr,
    output logic [2*CW-1:0] o_rd_data
);

    logic [2*CW-1:0] r_mem [256];

    always_ff @(posedge clk) begin
        if (i_preset) begin
            for (int k = 0; k < INIT_LEN; k++) begin
                r_mem[8'(256 - k)] <= {HX0 - CW'(k), HY0};
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_scan_data = r_mem[i_scan_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/ee354_snake_engine.sv
// Snake movement engine: next-head and wall check on Tick, serial self-collision scan
// over the body ring, then a one-cycle commit of the new head.
module ee354_snake_engine
    import ee354_snake_pkg::*;
#(
    parameter int GRID     = GRID_DEF,
    parameter int INIT_LEN = INIT_LEN_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    ee354_snake_engine_if.slave  io_bus
);

    localparam logic [7:0]    MAX_LEN  = 8'(GRID * GRID);
    localparam logic [7:0]    LEN0     = 8'(INIT_LEN);
    localparam logic [CW-1:0] LAST     = CW'(GRID - 1);
    localparam logic [CW-1:0] HX0      = CW'(GRID / 2);
    localparam logic [CW-1:0] HY0      = CW'(GRID / 2);

    eng_state_t      r_state, w_state_nxt;
    dir_t            r_dir, r_pdir, w_req;
    logic [7:0]      r_head_ptr, r_idx, r_len, w_last;
    logic            r_coll, r_eat;
    logic [CW-1:0]   r_hx, r_hy, r_nx, r_ny, w_cx, w_cy;
    logic            w_off, w_init, w_move, w_hit, w_commit, w_busy, w_ate;
    logic            r_rd_vld;
    logic [2*CW-1:0] w_scan_data, w_rd_data;

    assign w_req  = dir_t'(io_bus.Dir_In);
    assign w_init = io_bus.q_I || (r_state == S_INIT);
    assign w_move = (r_state == S_WAIT) && io_bus.Tick && io_bus.q_Run &&
                    !r_coll && (r_len < MAX_LEN);
    assign w_hit  = (w_scan_data == {r_nx, r_ny});
    // The tail cell is only an obstacle when the snake grows this move.
    assign w_last = r_eat ? r_len - 8'd1 : r_len - 8'd2;

    always_comb begin
        w_cx  = r_hx;
        w_cy  = r_hy;
        w_off = 1'b0;
        unique case (r_pdir)
            DIR_R: if (r_hx == LAST) w_off = 1'b1; else w_cx = r_hx + 1'b1;
            DIR_L: if (r_hx == '0)   w_off = 1'b1; else w_cx = r_hx - 1'b1;
            DIR_U: if (r_hy == '0)   w_off = 1'b1; else w_cy = r_hy - 1'b1;
            DIR_D: if (r_hy == LAST) w_off = 1'b1; else w_cy = r_hy + 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_INIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            S_INIT:   if (!io_bus.q_I) w_state_nxt = S_WAIT;
            S_WAIT:   if (w_move && !w_off) w_state_nxt = S_SCAN;
            S_SCAN: begin
                w_busy = 1'b1;
                if (w_hit)                w_state_nxt = S_WAIT;
                else if (r_idx == w_last) w_state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                w_busy      = 1'b1;
                w_commit    = !io_bus.q_I;
                w_state_nxt = S_WAIT;
            end
        endcase
        if (io_bus.q_I) w_state_nxt = S_INIT;
        w_ate = w_commit && r_eat;
    end

    // Reversal is judged against the committed direction, so two quick strobes
    // (e.g. U then L while moving R) cannot fold the head back onto the neck.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset || w_init) begin
            r_len      <= LEN0;
            r_coll     <= 1'b0;
            r_dir      <= DIR_R;
            r_pdir     <= DIR_R;
            r_head_ptr <= 8'd0;
            r_idx      <= 8'd0;
            r_hx       <= HX0;
            r_hy       <= HY0;
        end else begin
            if ((r_state == S_WAIT) && io_bus.Dir_Valid && (w_req != opposite(r_dir)))
                r_pdir <= w_req;
            if (w_move) begin
                if (w_off) r_coll <= 1'b1;
                else       r_idx  <= 8'd0;
            end
            if (r_state == S_SCAN) begin
                if (w_hit) r_coll <= 1'b1;
                else       r_idx  <= r_idx + 8'd1;
            end
            if (w_commit) begin
                r_head_ptr <= r_head_ptr + 8'd1;
                r_dir      <= r_pdir;
                r_hx       <= r_nx;
                r_hy       <= r_ny;
                if (r_eat && (r_len < MAX_LEN)) r_len <= r_len + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_move && !w_off) begin
            r_nx  <= w_cx;
            r_ny  <= w_cy;
            r_eat <= (w_cx == io_bus.Food_X) && (w_cy == io_bus.Food_Y);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_rd_vld <= 1'b0;
        else       r_rd_vld <= (io_bus.Rd_Idx < r_len);
    end

    ee354_snake_ring #(
        .CW       (CW),
        .INIT_LEN (INIT_LEN),
        .HX0      (HX0),
        .HY0      (HY0)
    ) u_ring (
        .clk         (Clk),
        .rst         (Reset),
        .i_preset    (w_init),
        .i_we        (w_commit),
        .i_waddr     (r_head_ptr + 8'd1),
        .i_wdata     ({r_nx, r_ny}),
        .i_scan_addr (r_head_ptr - r_idx),
        .o_scan_data (w_scan_data),
        .i_rd_addr   (r_head_ptr - io_bus.Rd_Idx),
        .o_rd_data   (w_rd_data)
    );

    assign io_bus.Collision = r_coll;
    assign io_bus.Length    = r_len;
    assign io_bus.Ate       = w_ate;
    assign io_bus.Head_X    = r_hx;
    assign io_bus.Head_Y    = r_hy;
    assign io_bus.Busy      = w_busy;
    assign io_bus.Rd_X      = w_rd_data[2*CW-1:CW];
    assign io_bus.Rd_Y      = w_rd_data[CW-1:0];
    assign io_bus.Rd_Vld    = r_rd_vld;

endmodule

// File: tb/tb_ee354_snake_engine.sv
// Directed bench for ee354_snake_engine: init, movement, eating, direction filtering,
// wall and self collision, tail-vacate boundary and abort of a scan by q_I.
module tb_ee354_snake_engine;

    logic Clk = 1'b0;
    logic Reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_cnt;
    int   ate_cnt;

    ee354_snake_engine_if #(.CW(4)) bus ();

    ee354_snake_engine #(.GRID(15), .INIT_LEN(3), .CW(4)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .io_bus (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic init_pulse();
        bus.q_I = 1'b1;
        cyc();
        bus.q_I = 1'b0;
        cyc();
    endtask

    task automatic steer(input logic [1:0] d);
        bus.Dir_In    = d;
        bus.Dir_Valid = 1'b1;
        cyc();
        bus.Dir_Valid = 1'b0;
    endtask

    task automatic move();
        int guard;
        bus.Tick = 1'b1;
        cyc();
        bus.Tick = 1'b0;
        busy_cnt = 0;
        ate_cnt  = 0;
        guard    = 0;
        while (bus.Busy === 1'b1 && guard < 600) begin
            if (bus.Ate === 1'b1) ate_cnt++;
            busy_cnt++;
            guard++;
            cyc();
        end
        if (guard >= 600) chk("move_timeout", guard, 0);
    endtask

    task automatic food(input logic [3:0] x, input logic [3:0] y);
        bus.Food_X = x;
        bus.Food_Y = y;
    endtask

    task automatic rd(input logic [7:0] idx);
        bus.Rd_Idx = idx;
        cyc();
    endtask

    initial begin
        Reset = 1'b1;
        bus.q_I = 1'b0; bus.q_Run = 1'b0; bus.Tick = 1'b0;
        bus.Dir_In = 2'b00; bus.Dir_Valid = 1'b0;
        bus.Food_X = 4'd0; bus.Food_Y = 4'd0; bus.Rd_Idx = 8'd0;
        cyc(); cyc();
        chk("rst_collision", bus.Collision, 0);
        chk("rst_length", bus.Length, 3);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_ate", bus.Ate, 0);
        chk("rst_rd_x", bus.Rd_X, 0);
        chk("rst_rd_vld", bus.Rd_Vld, 0);
        Reset = 1'b0;
        cyc();

        // Initial snake
        init_pulse();
        rd(8'd2);
        chk("init_length", bus.Length, 3);
        chk("init_head_x", bus.Head_X, 7);
        chk("init_head_y", bus.Head_Y, 7);
        chk("init_collision", bus.Collision, 0);
        chk("init_rd2_x", bus.Rd_X, 5);
        chk("init_rd2_y", bus.Rd_Y, 7);
        chk("init_rd2_vld", bus.Rd_Vld, 1);
        rd(8'd3);
        chk("init_rd3_vld", bus.Rd_Vld, 0);

        // Tick without q_Run is ignored
        move();
        chk("norun_busy", busy_cnt, 0);
        chk("norun_head_x", bus.Head_X, 7);

        // Three plain moves right
        bus.q_Run = 1'b1;
        move();
        chk("mv1_busy_cycles", busy_cnt, 3);
        chk("mv1_ate", ate_cnt, 0);
        move();
        chk("mv2_ate", ate_cnt, 0);
        move();
        chk("mv3_ate", ate_cnt, 0);
        chk("mv3_head_x", bus.Head_X, 10);
        chk("mv3_head_y", bus.Head_Y, 7);
        chk("mv3_length", bus.Length, 3);

        // Eat at (11,7)
        food(4'd11, 4'd7);
        move();
        chk("eat_ate_cycles", ate_cnt, 1);
        chk("eat_busy_cycles", busy_cnt, 4);
        chk("eat_length", bus.Length, 4);
        chk("eat_head_x", bus.Head_X, 11);
        food(4'd0, 4'd0);
        rd(8'd3);
        chk("eat_rd3_x", bus.Rd_X, 8);
        chk("eat_rd3_y", bus.Rd_Y, 7);
        chk("eat_rd3_vld", bus.Rd_Vld, 1);
        rd(8'd4);
        chk("eat_rd4_vld", bus.Rd_Vld, 0);

        // Reversal L while moving R is dropped
        steer(2'b01);
        move();
        chk("rev_head_x", bus.Head_X, 12);
        chk("rev_head_y", bus.Head_Y, 7);
        // U accepted; following L is still a reversal of committed R
        steer(2'b10);
        steer(2'b01);
        move();
        chk("ul_head_x", bus.Head_X, 12);
        chk("ul_head_y", bus.Head_Y, 6);

        // Wall at x=14
        steer(2'b00);
        move();
        move();
        chk("wall_pre_x", bus.Head_X, 14);
        move();
        chk("wall_busy", busy_cnt, 0);
        chk("wall_collision", bus.Collision, 1);
        chk("wall_head_x", bus.Head_X, 14);
        chk("wall_head_y", bus.Head_Y, 6);
        move();
        chk("wall_ignored_x", bus.Head_X, 14);
        chk("wall_ignored_len", bus.Length, 4);
        chk("wall_sticky", bus.Collision, 1);
        init_pulse();
        chk("wall_clr_collision", bus.Collision, 0);
        chk("wall_clr_length", bus.Length, 3);
        chk("wall_clr_head_x", bus.Head_X, 7);

        // Length-5 snake turns D,L,U into its own body
        food(4'd8, 4'd7);
        move();
        food(4'd9, 4'd7);
        move();
        chk("self_len5", bus.Length, 5);
        food(4'd0, 4'd0);
        steer(2'b11);
        move();
        steer(2'b01);
        move();
        chk("self_pre_x", bus.Head_X, 8);
        chk("self_pre_y", bus.Head_Y, 8);
        steer(2'b10);
        move();
        chk("self_collision", bus.Collision, 1);
        chk("self_busy_cycles", busy_cnt, 4);
        chk("self_head_y", bus.Head_Y, 8);
        chk("self_length", bus.Length, 5);

        // Moving into the vacating tail cell is legal
        init_pulse();
        food(4'd8, 4'd7);
        move();
        food(4'd0, 4'd0);
        steer(2'b11);
        move();
        steer(2'b01);
        move();
        steer(2'b10);
        move();
        chk("tail_collision", bus.Collision, 0);
        chk("tail_busy_cycles", busy_cnt, 4);
        chk("tail_head_x", bus.Head_X, 7);
        chk("tail_head_y", bus.Head_Y, 7);
        chk("tail_length", bus.Length, 4);

        // Same path but food on the tail: tail stays, so it is a hit
        init_pulse();
        food(4'd8, 4'd7);
        move();
        food(4'd0, 4'd0);
        steer(2'b11);
        move();
        steer(2'b01);
        move();
        food(4'd7, 4'd7);
        steer(2'b10);
        move();
        chk("tailfood_collision", bus.Collision, 1);
        chk("tailfood_ate", ate_cnt, 0);
        chk("tailfood_length", bus.Length, 4);
        chk("tailfood_head_y", bus.Head_Y, 8);

        // q_I mid-scan aborts
        init_pulse();
        food(4'd8, 4'd7);
        move();
        food(4'd0, 4'd0);
        chk("abort_pre_len", bus.Length, 4);
        bus.Tick = 1'b1;
        cyc();
        bus.Tick = 1'b0;
        chk("abort_in_scan", bus.Busy, 1);
        bus.q_I = 1'b1;
        cyc();
        chk("abort_busy", bus.Busy, 0);
        chk("abort_length", bus.Length, 3);
        chk("abort_head_x", bus.Head_X, 7);
        chk("abort_collision", bus.Collision, 0);
        bus.q_I = 1'b0;
        cyc();
        rd(8'd0);
        chk("abort_rd0_x", bus.Rd_X, 7);
        rd(8'd1);
        chk("abort_rd1_x", bus.Rd_X, 6);
        chk("abort_rd1_y", bus.Rd_Y, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
